// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants, error codes and controller states for the plugboard.
package enigma_pkg;
  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;
  localparam int MAX_PAIRS   = 10;
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_USED  = 2'd2,
    ERR_FULL  = 2'd3
  } err_e;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    WRITE = 2'd2
  } state_e;
endpackage

// File: rtl/plug_map.sv
// plug_map: letter map register file with a dual swap write, identity restore,
// one registered lookup port and two combinational check ports.
module plug_map #(
  parameter int N = 26,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restore,
  input  logic         we,
  input  logic [W-1:0] wa0,
  input  logic [W-1:0] wd0,
  input  logic [W-1:0] wa1,
  input  logic [W-1:0] wd1,
  input  logic [W-1:0] ra0,
  input  logic [W-1:0] ra1,
  input  logic [W-1:0] la,
  output logic [W-1:0] rd0,
  output logic [W-1:0] rd1,
  output logic [W-1:0] lookup_out
);
  localparam logic [W-1:0] NL = W'(N);
  logic [W-1:0] map [N];
  // Out-of-range letters map to themselves so callers never index past the table.
  assign rd0 = ra0 < NL ? map[ra0] : ra0;
  assign rd1 = ra1 < NL ? map[ra1] : ra1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) map[i] <= W'(i);
      lookup_out <= '0;
    end else begin
      if (restore) begin
        for (int i = 0; i < N; i++) map[i] <= W'(i);
      end else if (we) begin
        map[wa0] <= wd0;
        map[wa1] <= wd1;
      end
      lookup_out <= la < NL ? map[la] : la;
    end
  end
endmodule

// File: rtl/plugboard_ctrl.sv
// plugboard_ctrl: pairs keypresses into validated reciprocal swaps, commits them
// into plug_map and serves the registered lookup port.
module plugboard_ctrl #(
  parameter int NUM_LETTERS = 26,
  parameter int MAX_PAIRS   = 10,
  parameter int LETTER_W    = 5
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [LETTER_W-1:0] key_letter,
  input  logic                cancel,
  input  logic                clear_all,
  input  logic [LETTER_W-1:0] lookup_in,
  output logic [LETTER_W-1:0] lookup_out,
  output logic                pending,
  output logic [LETTER_W-1:0] pending_letter,
  output logic [3:0]          pair_count,
  output logic                full,
  output logic                accept,
  output logic                error,
  output logic [1:0]          err_code
);
  import enigma_pkg::*;
  localparam logic [LETTER_W-1:0] NL   = LETTER_W'(NUM_LETTERS);
  localparam logic [3:0]          MAXC = 4'(MAX_PAIRS);
  state_e              state;
  logic [LETTER_W-1:0] second;
  logic [LETTER_W-1:0] key_img;
  logic [LETTER_W-1:0] pend_img;
  logic                key_ok;
  logic                key_plugged;
  logic                pend_plugged;
  logic [3:0]          count_inc;
  assign key_ok       = key_letter < NL;
  assign key_plugged  = key_img != key_letter;
  assign pend_plugged = pend_img != pending_letter;
  assign count_inc    = pair_count + 4'd1;
  plug_map #(.N(NUM_LETTERS), .W(LETTER_W)) u_map (
    .clk        (CLOCK_50),
    .rst_n      (reset),
    .restore    (clear_all),
    .we         (state == WRITE && !clear_all),
    .wa0        (pending_letter),
    .wd0        (second),
    .wa1        (second),
    .wd1        (pending_letter),
    .ra0        (key_letter),
    .ra1        (pending_letter),
    .la         (lookup_in),
    .rd0        (key_img),
    .rd1        (pend_img),
    .lookup_out (lookup_out)
  );
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pending        <= 1'b0;
      pending_letter <= '0;
      second         <= '0;
      pair_count     <= '0;
      full           <= 1'b0;
      accept         <= 1'b0;
      error          <= 1'b0;
      err_code       <= ERR_NONE;
    end else begin
      accept   <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      if (clear_all) begin
        state          <= IDLE;
        pending        <= 1'b0;
        pending_letter <= '0;
        pair_count     <= '0;
        full           <= 1'b0;
      end else begin
        case (state)
          WRITE: begin
            state          <= IDLE;
            pending        <= 1'b0;
            pending_letter <= '0;
            pair_count     <= count_inc;
            full           <= count_inc == MAXC;
            accept         <= 1'b1;
          end
          HOLD: begin
            if (cancel) begin
              state          <= IDLE;
              pending        <= 1'b0;
              pending_letter <= '0;
            end else if (key_valid) begin
              if (!key_ok) begin
                error    <= 1'b1;
                err_code <= ERR_RANGE;
              end else if (key_letter == pending_letter || key_plugged || pend_plugged) begin
                error    <= 1'b1;
                err_code <= ERR_USED;
              end else begin
                second <= key_letter;
                state  <= WRITE;
              end
            end
          end
          default: begin
            if (key_valid && !cancel) begin
              if (!key_ok) begin
                error    <= 1'b1;
                err_code <= ERR_RANGE;
              end else if (full) begin
                error    <= 1'b1;
                err_code <= ERR_FULL;
              end else if (key_plugged) begin
                error    <= 1'b1;
                err_code <= ERR_USED;
              end else begin
                pending_letter <= key_letter;
                pending        <= 1'b1;
                state          <= HOLD;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_plugboard_ctrl.sv
// tb_plugboard_ctrl: directed scenario tasks with hand-computed expectations.
module tb_plugboard_ctrl;
  logic       CLOCK_50;
  logic       reset;
  logic       key_valid;
  logic [4:0] key_letter;
  logic       cancel;
  logic       clear_all;
  logic [4:0] lookup_in;
  logic [4:0] lookup_out;
  logic       pending;
  logic [4:0] pending_letter;
  logic [3:0] pair_count;
  logic       full;
  logic       accept;
  logic       error;
  logic [1:0] err_code;
  int tests = 0;
  int fails = 0;

  plugboard_ctrl dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_letter     (key_letter),
    .cancel         (cancel),
    .clear_all      (clear_all),
    .lookup_in      (lookup_in),
    .lookup_out     (lookup_out),
    .pending        (pending),
    .pending_letter (pending_letter),
    .pair_count     (pair_count),
    .full           (full),
    .accept         (accept),
    .error          (error),
    .err_code       (err_code)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic press(input logic [4:0] l);
    key_letter = l;
    key_valid  = 1'b1;
    @(negedge CLOCK_50);
    key_valid  = 1'b0;
  endtask

  task automatic look(input logic [4:0] l, input logic [4:0] exp, input string name);
    lookup_in = l;
    @(negedge CLOCK_50);
    tests++;
    if (lookup_out !== exp) begin
      fails++;
      $display("FAIL %s: lookup(%0d) got %0d expected %0d", name, l, lookup_out, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; key_valid = 1'b0; key_letter = '0; cancel = 1'b0;
    clear_all = 1'b0; lookup_in = 5'd9;
    repeat (2) @(negedge CLOCK_50);
    tests++;
    if ({pending, pending_letter, pair_count, full, accept, error, err_code, lookup_out} !== '0) begin
      fails++;
      $display("FAIL reset_vals: got p=%0d pl=%0d pc=%0d f=%0d a=%0d e=%0d ec=%0d lo=%0d expected all 0",
               pending, pending_letter, pair_count, full, accept, error, err_code, lookup_out);
    end
    reset = 1'b1;
    for (int i = 0; i < 26; i++) look(5'(i), 5'(i), "identity");
    look(5'd31, 5'd31, "lookup_out_of_range");
    tests++;
    if (pair_count !== 4'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_count: got pc=%0d full=%0d expected 0 0", pair_count, full);
    end
  endtask

  task automatic test_pair;
    press(5'd0);
    tests++;
    if (pending !== 1'b1 || pending_letter !== 5'd0) begin
      fails++;
      $display("FAIL first_pending: got %0d/%0d expected 1/0", pending, pending_letter);
    end
    press(5'd16);
    tests++;
    if (accept !== 1'b0 || pending !== 1'b1) begin
      fails++;
      $display("FAIL write_cycle: got accept=%0d pending=%0d expected 0 1", accept, pending);
    end
    @(negedge CLOCK_50);
    tests++;
    if (accept !== 1'b1 || pair_count !== 4'd1 || pending !== 1'b0) begin
      fails++;
      $display("FAIL pair_commit: got accept=%0d pc=%0d pending=%0d expected 1 1 0", accept, pair_count, pending);
    end
    look(5'd0, 5'd16, "pair_a");
    tests++;
    if (accept !== 1'b0) begin
      fails++;
      $display("FAIL accept_pulse: got %0d expected 0", accept);
    end
    look(5'd16, 5'd0, "pair_q");
    look(5'd5, 5'd5, "pair_unplugged");
  endtask

  task automatic test_errors;
    press(5'd16);
    tests++;
    if (error !== 1'b1 || err_code !== 2'd2 || pending !== 1'b0) begin
      fails++;
      $display("FAIL used_idle: got e=%0d ec=%0d p=%0d expected 1 2 0", error, err_code, pending);
    end
    press(5'd1);
    tests++;
    if (error !== 1'b0 || err_code !== 2'd0 || pending !== 1'b1) begin
      fails++;
      $display("FAIL err_clear: got e=%0d ec=%0d p=%0d expected 0 0 1", error, err_code, pending);
    end
    press(5'd1);
    tests++;
    if (error !== 1'b1 || err_code !== 2'd2 || pending !== 1'b1 || pending_letter !== 5'd1) begin
      fails++;
      $display("FAIL used_same: got e=%0d ec=%0d p=%0d pl=%0d expected 1 2 1 1", error, err_code, pending, pending_letter);
    end
    press(5'd27);
    tests++;
    if (error !== 1'b1 || err_code !== 2'd1 || pending !== 1'b1) begin
      fails++;
      $display("FAIL range_hold: got e=%0d ec=%0d p=%0d expected 1 1 1", error, err_code, pending);
    end
    press(5'd16);
    tests++;
    if (err_code !== 2'd2 || pending_letter !== 5'd1) begin
      fails++;
      $display("FAIL used_hold_plugged: got ec=%0d pl=%0d expected 2 1", err_code, pending_letter);
    end
    cancel = 1'b1;
    @(negedge CLOCK_50);
    cancel = 1'b0;
    tests++;
    if (pending !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL cancel_hold: got p=%0d e=%0d expected 0 0", pending, error);
    end
    press(5'd26);
    tests++;
    if (error !== 1'b1 || err_code !== 2'd1 || pending !== 1'b0) begin
      fails++;
      $display("FAIL range_idle: got e=%0d ec=%0d p=%0d expected 1 1 0", error, err_code, pending);
    end
  endtask

  task automatic test_full;
    logic [4:0] pa [9] = '{5'd1, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14, 5'd17, 5'd19};
    for (int i = 0; i < 9; i++) begin
      press(pa[i]);
      press(pa[i] + 5'd1);
      @(negedge CLOCK_50);
    end
    tests++;
    if (pair_count !== 4'd10 || full !== 1'b1) begin
      fails++;
      $display("FAIL full_set: got pc=%0d full=%0d expected 10 1", pair_count, full);
    end
    press(5'd2);
    tests++;
    if (error !== 1'b1 || err_code !== 2'd3 || pair_count !== 4'd10 || pending !== 1'b0) begin
      fails++;
      $display("FAIL full_reject: got e=%0d ec=%0d pc=%0d p=%0d expected 1 3 10 0", error, err_code, pair_count, pending);
    end
    look(5'd19, 5'd20, "full_map");
    clear_all = 1'b1;
    @(negedge CLOCK_50);
    clear_all = 1'b0;
    tests++;
    if (pair_count !== 4'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle: got pc=%0d full=%0d expected 0 0", pair_count, full);
    end
    look(5'd19, 5'd19, "clear_map");
  endtask

  task automatic test_cancel;
    press(5'd3);
    key_letter = 5'd4; key_valid = 1'b1; cancel = 1'b1;
    @(negedge CLOCK_50);
    key_valid = 1'b0; cancel = 1'b0;
    @(negedge CLOCK_50);
    tests++;
    if (pending !== 1'b0 || error !== 1'b0 || accept !== 1'b0) begin
      fails++;
      $display("FAIL cancel_prio: got p=%0d e=%0d a=%0d expected 0 0 0", pending, error, accept);
    end
    press(5'd3);
    press(5'd4);
    @(negedge CLOCK_50);
    tests++;
    if (accept !== 1'b1 || pair_count !== 4'd1) begin
      fails++;
      $display("FAIL cancel_recommit: got a=%0d pc=%0d expected 1 1", accept, pair_count);
    end
    look(5'd3, 5'd4, "cancel_map");
  endtask

  task automatic test_clear_write;
    press(5'd5);
    press(5'd6);
    clear_all = 1'b1;
    @(negedge CLOCK_50);
    clear_all = 1'b0;
    tests++;
    if (accept !== 1'b0 || pair_count !== 4'd0 || pending !== 1'b0) begin
      fails++;
      $display("FAIL clear_write: got a=%0d pc=%0d p=%0d expected 0 0 0", accept, pair_count, pending);
    end
    look(5'd5, 5'd5, "clear_write_f");
    look(5'd3, 5'd3, "clear_write_d");
  endtask

  task automatic test_write_drop;
    press(5'd7);
    press(5'd8);
    key_letter = 5'd30; key_valid = 1'b1;
    @(negedge CLOCK_50);
    key_valid = 1'b0;
    tests++;
    if (accept !== 1'b1 || error !== 1'b0 || pair_count !== 4'd1) begin
      fails++;
      $display("FAIL write_drop: got a=%0d e=%0d pc=%0d expected 1 0 1", accept, error, pair_count);
    end
    @(negedge CLOCK_50);
    tests++;
    if (error !== 1'b0 || pending !== 1'b0) begin
      fails++;
      $display("FAIL write_drop_after: got e=%0d p=%0d expected 0 0", error, pending);
    end
  endtask

  task automatic test_async_reset;
    lookup_in = 5'd7;
    press(5'd9);
    tests++;
    if (pending !== 1'b1 || lookup_out !== 5'd8) begin
      fails++;
      $display("FAIL pre_reset: got p=%0d lo=%0d expected 1 8", pending, lookup_out);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({pending, pending_letter, pair_count, full, accept, error, err_code, lookup_out} !== '0) begin
      fails++;
      $display("FAIL async_reset: got p=%0d pl=%0d pc=%0d f=%0d lo=%0d expected all 0",
               pending, pending_letter, pair_count, full, lookup_out);
    end
    @(negedge CLOCK_50);
    reset = 1'b1;
    look(5'd7, 5'd7, "reset_map");
  endtask

  initial begin
    test_reset();
    test_pair();
    test_errors();
    test_full();
    test_cancel();
    test_clear_write();
    test_write_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
